rr_select_arbiter: RTL

Round-robin arbiter that owns the select input of the shared N:1 datapath `mux`. It accepts one request line per source and grants exactly one source at a time. It drives the mux select with the granted index and holds the grant until a multi-beat transfer completes or the owner withdraws. It sits directly upstream of the `mux` instance, so `o_select` connects to the mux `i_select` and `NUM_INPUTS` matches on both blocks.

---
 rtl/rr_select_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_select_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_select_arbiter
//  Brief    : Round-robin arbiter that owns the select input of the shared
//             N:1 datapath mux. Grants one source at a time, holds the grant
//             across a multi-beat transfer and rotates priority on release.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_select_arbiter #(
    parameter int NUM_INPUTS = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_INPUTS-1:0]                 i_req,
    input  logic                                  i_ready,
    input  logic                                  i_last,
    output logic                                  o_valid,
    output logic [NUM_INPUTS-1:0]                 o_grant,
    output logic [$clog2(NUM_INPUTS)-1:0]         o_select
);

    localparam int SELECT_BITS = $clog2(NUM_INPUTS);

    // State encoding
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [SELECT_BITS-1:0] c_LAST_INDEX = SELECT_BITS'(NUM_INPUTS - 1);

    // ------------------------------------------------------------------------
    // Rotating first-set search starting at 'start'. Returns {found, index}.
    // Iterating from the farthest offset back to the nearest lets the nearest
    // requester overwrite the result, so the lowest offset from 'start' wins.
    // ------------------------------------------------------------------------
    function automatic logic [SELECT_BITS:0] f_arbitrate(
        input logic [NUM_INPUTS-1:0]  req,
        input logic [SELECT_BITS-1:0] start
    );
        logic [SELECT_BITS:0] result;
        logic [SELECT_BITS:0] idx;
        result = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            idx = {1'b0, start} + (SELECT_BITS + 1)'(i);
            if (idx >= (SELECT_BITS + 1)'(NUM_INPUTS)) begin
                idx = idx - (SELECT_BITS + 1)'(NUM_INPUTS);
            end
            if (req[idx[SELECT_BITS-1:0]]) begin
                result = {1'b1, idx[SELECT_BITS-1:0]};
            end
        end
        return result;
    endfunction

    // Binary index to one-hot vector
    function automatic logic [NUM_INPUTS-1:0] f_onehot(
        input logic [SELECT_BITS-1:0] idx
    );
        logic [NUM_INPUTS-1:0] vec;
        vec = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            vec[k] = (idx == SELECT_BITS'(k));
        end
        return vec;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]             r_state;
    logic [SELECT_BITS-1:0] r_owner;
    logic [SELECT_BITS-1:0] r_ptr;
    logic [NUM_INPUTS-1:0]  r_grant;

    // ------------------------------------------------------------------------
    // Combinational event decode and arbitration
    // ------------------------------------------------------------------------
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_complete;
    logic                   w_abort;
    logic                   w_release;
    logic [SELECT_BITS-1:0] w_next_ptr;
    logic [NUM_INPUTS-1:0]  w_owner_onehot;
    logic [NUM_INPUTS-1:0]  w_rearb_req;
    logic [SELECT_BITS:0]   w_idle_arb;
    logic [SELECT_BITS:0]   w_busy_arb;

    assign w_busy         = (r_state == c_BUSY);
    assign w_accept       = w_busy && i_ready;
    assign w_complete     = w_accept && i_last;
    // A completion takes precedence: an owner dropping its request on the
    // accepted last beat is treated as a normal completion.
    assign w_abort        = w_busy && !i_req[r_owner] && !w_accept;
    assign w_release      = w_complete || w_abort;
    assign w_next_ptr     = (r_owner == c_LAST_INDEX) ? '0 : r_owner + 1'b1;
    assign w_owner_onehot = f_onehot(r_owner);
    // On abort the departing owner must not win the same-edge re-arbitration
    assign w_rearb_req    = w_abort ? (i_req & ~w_owner_onehot) : i_req;
    assign w_idle_arb     = f_arbitrate(i_req, r_ptr);
    assign w_busy_arb     = f_arbitrate(w_rearb_req, w_next_ptr);

    // Grant FSM: acquire from IDLE, hold while BUSY, rotate and re-arbitrate on release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_idle_arb[SELECT_BITS]) begin
                        r_state <= c_BUSY;
                        r_owner <= w_idle_arb[SELECT_BITS-1:0];
                        r_grant <= f_onehot(w_idle_arb[SELECT_BITS-1:0]);
                    end
                end
                c_BUSY: begin
                    if (w_release) begin
                        r_ptr <= w_next_ptr;
                        if (w_busy_arb[SELECT_BITS]) begin
                            r_owner <= w_busy_arb[SELECT_BITS-1:0];
                            r_grant <= f_onehot(w_busy_arb[SELECT_BITS-1:0]);
                        end else begin
                            // Owner index is kept so the mux select stays stable
                            r_state <= c_IDLE;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_valid  = w_busy;
    assign o_select = r_owner;
    assign o_grant  = r_grant;

endmodule
`default_nettype wire
